// File: rtl/tom_ctl.sv
// -----------------------------------------------------------------------------
// tom_ctl -- sprite motion controller for "Tom".
//
// The sprite moves left/right and jumps under a simple gravity model. All
// motion is frame-paced: position, velocity and state change only on the
// clk edge that sees the rising edge of vblnk (one update per video frame).
//
// Ports
//   clk          system clock (single domain)
//   rst          asynchronous reset, active low
//   vblnk        vertical blanking from the VGA timing chain
//   left         move-left request (level)
//   right        move-right request (level)
//   jump         jump request (level)
//   tom_x        sprite top-left x (registered)
//   tom_y        sprite top-left y (registered)
//   airborne     high while rising or falling (registered)
//   facing_left  last horizontal direction, 1 = left (registered)
// -----------------------------------------------------------------------------
module tom_ctl #(
    parameter int START_X  = 100,
    parameter int GROUND_Y = 450,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 736,
    parameter int STEP     = 4,
    parameter int JUMP_V0  = 16,
    parameter int GRAVITY  = 1,
    parameter int VMAX     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       left,
    input  logic       right,
    input  logic       jump,
    output logic [9:0] tom_x,
    output logic [9:0] tom_y,
    output logic       airborne,
    output logic       facing_left
);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } state_t;

    // Sized copies of the parameters so every compare/add is width-matched.
    localparam logic signed [10:0] STEP_S   = 11'(STEP);
    localparam logic signed [10:0] XMIN_S   = 11'(X_MIN);
    localparam logic        [10:0] XMAX_11  = 11'(X_MAX);
    localparam logic        [10:0] GND_11   = 11'(GROUND_Y);
    localparam logic        [6:0]  GRAV_7   = 7'(GRAVITY);
    localparam logic        [5:0]  GRAV_6   = 6'(GRAVITY);
    localparam logic        [6:0]  VMAX_7   = 7'(VMAX);

    state_t     state, state_nx;
    logic [5:0] vel, vel_nx;
    logic [9:0] x_nx, y_nx;
    logic       fl_nx;
    logic       vblnk_q;
    logic       tick;

    // One tick per frame: vblnk rising edge. vblnk_q resets high so a vblnk
    // already asserted when reset releases does not look like a new edge.
    assign tick = vblnk & ~vblnk_q;

    // ---------------------------------------------------------------- horizontal
    // Left step is done in 11-bit signed so x < STEP goes negative and clamps
    // to X_MIN instead of wrapping to a large unsigned value.
    logic signed [10:0] x_dec;
    logic        [10:0] x_inc;

    assign x_dec = $signed({1'b0, tom_x}) - STEP_S;
    assign x_inc = {1'b0, tom_x} + 11'(STEP);

    always_comb begin
        x_nx  = tom_x;
        fl_nx = facing_left;
        if (left && !right) begin
            x_nx  = (x_dec < XMIN_S) ? 10'(X_MIN) : x_dec[9:0];
            fl_nx = 1'b1;
        end else if (right && !left) begin
            x_nx  = (x_inc > XMAX_11) ? 10'(X_MAX) : x_inc[9:0];
            fl_nx = 1'b0;
        end
    end

    // ------------------------------------------------------------------ vertical
    // Falling: accelerate by GRAVITY, capped at VMAX, then test for landing
    // with one extra bit of headroom on the sum.
    logic [6:0]  v_inc;
    logic [5:0]  v_fall;
    logic [10:0] y_fall;

    assign v_inc  = {1'b0, vel} + GRAV_7;
    assign v_fall = (v_inc > VMAX_7) ? 6'(VMAX) : v_inc[5:0];
    assign y_fall = {1'b0, tom_y} + {5'b0, v_fall};

    always_comb begin
        state_nx = state;
        vel_nx   = vel;
        y_nx     = tom_y;
        case (state)
            GROUND: begin
                // Take-off tick only arms the velocity; y moves from the next tick.
                if (jump) begin
                    state_nx = RISE;
                    vel_nx   = 6'(JUMP_V0);
                end
            end
            RISE: begin
                if ({4'b0, vel} > tom_y) begin
                    // Would go above the screen top: pin to row 0 and start falling.
                    y_nx     = '0;
                    vel_nx   = '0;
                    state_nx = FALL;
                end else begin
                    y_nx = tom_y - {4'b0, vel};
                    // <= rather than == keeps a GRAVITY larger than the
                    // remaining velocity from underflowing vel.
                    if (vel <= GRAV_6) begin
                        vel_nx   = '0;
                        state_nx = FALL;
                    end else begin
                        vel_nx = vel - GRAV_6;
                    end
                end
            end
            FALL: begin
                // jump is not looked at here, so holding it through the
                // landing tick cannot retrigger until the following tick.
                if (y_fall >= GND_11) begin
                    y_nx     = 10'(GROUND_Y);
                    vel_nx   = '0;
                    state_nx = GROUND;
                end else begin
                    y_nx   = y_fall[9:0];
                    vel_nx = v_fall;
                end
            end
            default: begin
                y_nx     = 10'(GROUND_Y);
                vel_nx   = '0;
                state_nx = GROUND;
            end
        endcase
    end

    // --------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vblnk_q     <= 1'b1;
            tom_x       <= 10'(START_X);
            tom_y       <= 10'(GROUND_Y);
            state       <= GROUND;
            vel         <= '0;
            airborne    <= 1'b0;
            facing_left <= 1'b0;
        end else begin
            vblnk_q <= vblnk;
            if (tick) begin
                tom_x       <= x_nx;
                facing_left <= fl_nx;
                tom_y       <= y_nx;
                vel         <= vel_nx;
                state       <= state_nx;
                airborne    <= (state_nx != GROUND);
            end
        end
    end

endmodule

// File: tb/tb_tom_ctl.sv
// -----------------------------------------------------------------------------
// tb_tom_ctl -- self-checking bench for tom_ctl.
// A frame-level model (signed velocity, up = positive) predicts the sprite
// after every vblnk pulse; directed steps pin the documented corner cases and
// a randomized run follows.
// -----------------------------------------------------------------------------
module tb_tom_ctl;

    localparam int START_X  = 100;
    localparam int GROUND_Y = 450;
    localparam int X_MIN    = 0;
    localparam int X_MAX    = 738;   // not a multiple of STEP, so x can reach 2
    localparam int STEP     = 4;
    localparam int JUMP_V0  = 16;
    localparam int GRAVITY  = 1;
    localparam int VMAX     = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vblnk = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       jump = 1'b0;
    logic [9:0] tom_x, tom_y;
    logic       airborne, facing_left;

    int compared   = 0;
    int mismatched = 0;

    // model state
    int mx, my, mv;
    bit mair, mfl;

    tom_ctl #(
        .START_X(START_X), .GROUND_Y(GROUND_Y), .X_MIN(X_MIN), .X_MAX(X_MAX),
        .STEP(STEP), .JUMP_V0(JUMP_V0), .GRAVITY(GRAVITY), .VMAX(VMAX)
    ) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .left(left), .right(right),
        .jump(jump), .tom_x(tom_x), .tom_y(tom_y), .airborne(airborne),
        .facing_left(facing_left)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        mx = START_X; my = GROUND_Y; mv = 0; mair = 0; mfl = 0;
    endfunction

    // One frame of motion. mv > 0: rising at mv px/frame; mv <= 0 while
    // airborne: falling at -mv px/frame.
    function automatic void model_tick(bit l, bit r, bit j);
        int f;
        if (l && !r) begin
            mx  = (mx - STEP < X_MIN) ? X_MIN : mx - STEP;
            mfl = 1;
        end else if (r && !l) begin
            mx  = (mx + STEP > X_MAX) ? X_MAX : mx + STEP;
            mfl = 0;
        end
        if (!mair) begin
            if (j) begin mair = 1; mv = JUMP_V0; end
        end else if (mv > 0) begin
            if (mv > my) begin
                my = 0; mv = 0;
            end else begin
                my = my - mv;
                mv = mv - GRAVITY;
                if (mv < 0) mv = 0;
            end
        end else begin
            f = -mv + GRAVITY;
            if (f > VMAX) f = VMAX;
            if (my + f >= GROUND_Y) begin
                my = GROUND_Y; mv = 0; mair = 0;
            end else begin
                my = my + f; mv = -f;
            end
        end
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_x"},  int'(tom_x), mx);
        chk({tag, "_y"},  int'(tom_y), my);
        chk({tag, "_air"}, int'(airborne), int'(mair));
        chk({tag, "_fl"}, int'(facing_left), int'(mfl));
    endtask

    // One vblnk pulse: hi clocks high (one tick), lo clocks low.
    task automatic frame(input bit l, input bit r, input bit j, input int hi, input int lo);
        @(negedge clk);
        left = l; right = r; jump = j; vblnk = 1'b1;
        repeat (hi) @(negedge clk);
        vblnk = 1'b0;
        repeat (lo) @(negedge clk);
        model_tick(l, r, j);
    endtask

    initial begin
        int x_hold, y_hold;
        bit rl, rr, rj;

        // ---- reset with vblnk already high: release must not tick
        model_reset();
        vblnk = 1'b1; right = 1'b1;
        repeat (3) @(negedge clk);
        check_model("reset");
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_tick_after_reset_x", int'(tom_x), START_X);
        vblnk = 1'b0; right = 1'b0;
        repeat (2) @(negedge clk);

        // ---- right for 10 ticks
        repeat (10) frame(0, 1, 0, 1, 2);
        check_model("right10");
        chk("right10_x_const", int'(tom_x), 140);
        chk("right10_y_const", int'(tom_y), 450);

        // ---- push into the right wall, then walk left down to x=2
        repeat (155) frame(0, 1, 0, 1, 1);
        check_model("right_wall");
        chk("right_wall_const", int'(tom_x), X_MAX);
        repeat (184) frame(1, 0, 0, 1, 1);
        chk("at_two", int'(tom_x), 2);
        frame(1, 0, 0, 1, 1);
        check_model("left_clamp1");
        chk("left_clamp1_const", int'(tom_x), 0);
        frame(1, 0, 0, 2, 1);
        chk("left_clamp2_const", int'(tom_x), 0);
        chk("left_clamp2_fl", int'(facing_left), 1);

        // ---- both / neither hold x and facing
        frame(1, 1, 0, 1, 1);
        check_model("both");
        frame(0, 0, 0, 1, 1);
        check_model("neither");

        // ---- single jump: 16 rise ticks then 16 fall ticks
        frame(0, 0, 1, 1, 1);
        check_model("takeoff");
        chk("takeoff_y", int'(tom_y), 450);
        repeat (16) frame(0, 0, 0, 1, 1);
        check_model("apex");
        chk("apex_y", int'(tom_y), 314);
        chk("apex_air", int'(airborne), 1);
        repeat (16) frame(0, 0, 0, 1, 1);
        check_model("land");
        chk("land_y", int'(tom_y), 450);
        chk("land_air", int'(airborne), 0);

        // ---- jump held through landing: no retrigger on landing tick
        frame(0, 0, 1, 1, 1);
        repeat (32) frame(0, 0, 1, 1, 1);
        check_model("held_land");
        chk("held_land_air", int'(airborne), 0);
        frame(0, 0, 1, 1, 1);
        check_model("held_retrigger");
        chk("held_retrigger_air", int'(airborne), 1);
        repeat (32) frame(0, 0, 0, 1, 1);
        check_model("held_done");

        // ---- long vblnk: exactly one update
        frame(0, 1, 0, 100, 2);
        check_model("long_vblnk");
        chk("long_vblnk_x", int'(tom_x), 4);
        // no ticks: outputs hold regardless of inputs
        x_hold = int'(tom_x); y_hold = int'(tom_y);
        left = 1'b1; right = 1'b0; jump = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_x", int'(tom_x), x_hold);
        chk("idle_y", int'(tom_y), y_hold);
        check_model("idle");

        // ---- reset mid-rise is asynchronous
        frame(0, 0, 1, 1, 1);
        repeat (3) frame(0, 0, 0, 1, 1);
        check_model("mid_rise");
        chk("mid_rise_y", int'(tom_y), 405);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_model("async_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // ---- randomized frames against the model
        for (int i = 0; i < 300; i++) begin
            rl = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 2) == 0);
            rj = ($urandom_range(0, 3) == 0);
            frame(rl, rr, rj, $urandom_range(1, 4), $urandom_range(1, 4));
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
